// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush scheduler for the 5-stage core.
// Merges per-stage stall requests and an internal multi-cycle EX sequencer
// (mult/div) into one stall vector. A flush overrides every stall and aborts
// any multi-cycle operation.
//
// Optional feature macro: STALL_PERF_CNT_EN
//   defined   -> stall_cycle_cnt counts cycles with stall[0]=1 and flush=0
//   undefined -> stall_cycle_cnt is tied to 0
//
// Sequencer states:
//   state | meaning
//   IDLE  | no multi-cycle op; a start request stalls EX and loads the counter
//   BUSY  | op running; EX held, counter decrements every cycle
//   DONE  | result valid in EX; wait for EX/MEM to advance (stall[4]=0)
module pipe_stall_ctrl #(
    parameter int STALL_WIDTH  = 6,
    parameter int MC_CNT_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_req_if,
    input  logic                    stall_req_id,
    input  logic                    stall_req_ex,
    input  logic                    stall_req_mem,
    input  logic                    flush,
    input  logic                    ex_mc_start,
    input  logic [MC_CNT_WIDTH-1:0] ex_mc_cycles,
    output logic [STALL_WIDTH-1:0]  stall,
    output logic                    ex_mc_busy,
    output logic                    ex_mc_done,
    output logic [31:0]             stall_cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Each vector stalls the requesting stage and everything upstream of it.
    localparam logic [STALL_WIDTH-1:0] STALL_MEM = STALL_WIDTH'(32'h1F);
    localparam logic [STALL_WIDTH-1:0] STALL_EX  = STALL_WIDTH'(32'h0F);
    localparam logic [STALL_WIDTH-1:0] STALL_ID  = STALL_WIDTH'(32'h07);
    localparam logic [STALL_WIDTH-1:0] STALL_IF  = STALL_WIDTH'(32'h03);

    localparam logic [MC_CNT_WIDTH-1:0] CNT_ONE = MC_CNT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [MC_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                    busy_q, done_q;
    logic                    mc_req;
    logic                    req_ex;
    logic [STALL_WIDTH-1:0]  stall_vec;

    // Effective EX request and the priority-encoded stall vector.
    always_comb begin
        mc_req    = ((state_q == IDLE) && ex_mc_start) || (state_q == BUSY);
        req_ex    = stall_req_ex | mc_req;
        stall_vec = '0;
        if (!rst || flush) begin
            stall_vec = '0;
        end else if (stall_req_mem) begin
            stall_vec = STALL_MEM;
        end else if (req_ex) begin
            stall_vec = STALL_EX;
        end else if (stall_req_id) begin
            stall_vec = STALL_ID;
        end else if (stall_req_if) begin
            stall_vec = STALL_IF;
        end
    end

    assign stall = stall_vec;

    // Sequencer next-state and counter; flush and reset both abort the op.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!rst || flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_mc_start) begin
                        state_d = BUSY;
                        cnt_d   = (ex_mc_cycles == '0) ? CNT_ONE : ex_mc_cycles;
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q - CNT_ONE;
                    // <= guards against a stray zero count locking the FSM.
                    if (cnt_q <= CNT_ONE) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!stall_vec[4]) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Sequencer registers with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == BUSY);
            done_q  <= (state_d == DONE);
        end
    end

    assign ex_mc_busy = busy_q;
    assign ex_mc_done = done_q;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Count PC-stalled cycles; flushed cycles never stall so they are skipped.
    always_comb begin
        perf_d = perf_q;
        if (stall_vec[0] && !flush) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Performance counter register, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign stall_cycle_cnt = perf_q;
`else
    assign stall_cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed bench for pipe_stall_ctrl with a scoreboard
// queue of expected per-cycle outputs.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
    logic        flush;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic [5:0]  stall;
    logic        ex_mc_busy, ex_mc_done;
    logic [31:0] stall_cycle_cnt;

`ifdef STALL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [5:0] s;
        logic       b;
        logic       d;
        logic [31:0] c;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 0;

    pipe_stall_ctrl #(.STALL_WIDTH(6), .MC_CNT_WIDTH(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_req_if    (stall_req_if),
        .stall_req_id    (stall_req_id),
        .stall_req_ex    (stall_req_ex),
        .stall_req_mem   (stall_req_mem),
        .flush           (flush),
        .ex_mc_start     (ex_mc_start),
        .ex_mc_cycles    (ex_mc_cycles),
        .stall           (stall),
        .ex_mc_busy      (ex_mc_busy),
        .ex_mc_done      (ex_mc_done),
        .stall_cycle_cnt (stall_cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive inputs, push expectation, compare at negedge, advance.
    // req = {mem, ex, id, if}
    task automatic step(input string tag, input logic r, input logic [3:0] req,
                        input logic fl, input logic st, input logic [5:0] n,
                        input logic [5:0] es, input logic eb, input logic ed);
        exp_t e;
        rst           = r;
        stall_req_mem = req[3];
        stall_req_ex  = req[2];
        stall_req_id  = req[1];
        stall_req_if  = req[0];
        flush         = fl;
        ex_mc_start   = st;
        ex_mc_cycles  = n;
        e.tag = tag; e.s = es; e.b = eb; e.d = ed;
        e.c   = PERF ? exp_cnt : 32'd0;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            assert (stall === e.s) else begin
                n_fail++;
                $error("FAIL %s stall got %b exp %b", e.tag, stall, e.s);
            end
            n_cmp++;
            assert (ex_mc_busy === e.b) else begin
                n_fail++;
                $error("FAIL %s busy got %b exp %b", e.tag, ex_mc_busy, e.b);
            end
            n_cmp++;
            assert (ex_mc_done === e.d) else begin
                n_fail++;
                $error("FAIL %s done got %b exp %b", e.tag, ex_mc_done, e.d);
            end
            n_cmp++;
            assert (stall_cycle_cnt === e.c) else begin
                n_fail++;
                $error("FAIL %s cnt got %0d exp %0d", e.tag, stall_cycle_cnt, e.c);
            end
        end
        if (!r) exp_cnt = 0;
        else if (es[0] && !fl) exp_cnt = exp_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall_req_if = 1'b1; stall_req_id = 1'b1; stall_req_ex = 1'b1;
        stall_req_mem = 1'b1; flush = 1'b0; ex_mc_start = 1'b1; ex_mc_cycles = 6'd3;
        @(posedge clk); #1;

        // reset and release
        step("rst_hold", 0, 4'b1111, 0, 1, 6'd3, 6'b000000, 0, 0);
        step("rst_rel",  1, 4'b1111, 0, 0, 6'd0, 6'b011111, 0, 0);
        // priority
        step("pri_ifid", 1, 4'b0011, 0, 0, 6'd0, 6'b000111, 0, 0);
        step("pri_mem",  1, 4'b1011, 0, 0, 6'd0, 6'b011111, 0, 0);
        step("pri_fl",   1, 4'b1011, 1, 0, 6'd0, 6'b000000, 0, 0);
        step("pri_if",   1, 4'b0001, 0, 0, 6'd0, 6'b000011, 0, 0);
        step("pri_ex",   1, 4'b0100, 0, 0, 6'd0, 6'b001111, 0, 0);
        step("pri_none", 1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 0);
        // N=3; extra ex request and ignored starts in BUSY/DONE
        step("n3_t0",    1, 4'b0000, 0, 1, 6'd3, 6'b001111, 0, 0);
        step("n3_t1",    1, 4'b0000, 0, 0, 6'd0, 6'b001111, 1, 0);
        step("n3_t2ex",  1, 4'b0100, 0, 0, 6'd0, 6'b001111, 1, 0);
        step("n3_t3st",  1, 4'b0000, 0, 1, 6'd5, 6'b001111, 1, 0);
        step("n3_t4",    1, 4'b0000, 0, 1, 6'd5, 6'b000000, 0, 1);
        step("n3_t5",    1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 0);
        // N=2 with MEM stall in BUSY (no extension) and in DONE (hold)
        step("h_c0",     1, 4'b0000, 0, 1, 6'd2, 6'b001111, 0, 0);
        step("h_c1mem",  1, 4'b1000, 0, 0, 6'd0, 6'b011111, 1, 0);
        step("h_c2",     1, 4'b0000, 0, 0, 6'd0, 6'b001111, 1, 0);
        step("h_c3",     1, 4'b1000, 0, 0, 6'd0, 6'b011111, 0, 1);
        step("h_c4",     1, 4'b1000, 0, 0, 6'd0, 6'b011111, 0, 1);
        step("h_c5",     1, 4'b1000, 0, 0, 6'd0, 6'b011111, 0, 1);
        step("h_c6",     1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 1);
        step("h_c7",     1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 0);
        // N=20 aborted by flush, then N=1
        step("fa_c0",    1, 4'b0000, 0, 1, 6'd20, 6'b001111, 0, 0);
        for (int i = 1; i <= 4; i++)
            step("fa_busy", 1, 4'b0000, 0, 0, 6'd0, 6'b001111, 1, 0);
        step("fa_c5fl",  1, 4'b0000, 1, 0, 6'd0, 6'b000000, 1, 0);
        step("fa_c6",    1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 0);
        step("fa_c7",    1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 0);
        step("n1_c8",    1, 4'b0000, 0, 1, 6'd1, 6'b001111, 0, 0);
        step("n1_c9",    1, 4'b0000, 0, 0, 6'd0, 6'b001111, 1, 0);
        step("n1_c10",   1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 1);
        step("n1_c11",   1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 0);
        // N=0 behaves as N=1
        step("n0_c0",    1, 4'b0000, 0, 1, 6'd0, 6'b001111, 0, 0);
        step("n0_c1",    1, 4'b0000, 0, 0, 6'd0, 6'b001111, 1, 0);
        step("n0_c2",    1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 1);
        step("n0_c3",    1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 0);
        // flush coinciding with start: nothing starts
        step("fs_c0",    1, 4'b0000, 1, 1, 6'd3, 6'b000000, 0, 0);
        step("fs_c1",    1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 0);
        // reset mid-operation
        step("rm_c0",    1, 4'b0000, 0, 1, 6'd5, 6'b001111, 0, 0);
        step("rm_c1",    1, 4'b0000, 0, 0, 6'd0, 6'b001111, 1, 0);
        step("rm_rst",   0, 4'b0100, 0, 0, 6'd0, 6'b000000, 1, 0);
        step("rm_after", 1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 0);
        // seven IF-stalled cycles, one flushed
        for (int i = 0; i < 7; i++) begin
            if (i == 3) step("pc_fl", 1, 4'b0001, 1, 0, 6'd0, 6'b000000, 0, 0);
            else        step("pc_if", 1, 4'b0001, 0, 0, 6'd0, 6'b000011, 0, 0);
        end
        step("pc_end",   1, 4'b0000, 0, 0, 6'd0, 6'b000000, 0, 0);

`ifdef STALL_PERF_CNT_EN
        // wrap from all-ones to zero on a stalled cycle
        rst = 1'b1; stall_req_if = 1'b1; flush = 1'b0;
        @(negedge clk);
        force dut.perf_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_q;
        @(negedge clk);
        n_cmp++;
        assert (stall_cycle_cnt === 32'd0) else begin
            n_fail++;
            $error("FAIL cnt_wrap got %h exp %h", stall_cycle_cnt, 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
